cic_comb_decimator: RTL
=======================

# cic_comb_decimator

Decimation and comb stage of the single-stage CIC decimator. It sits directly downstream of the integrator and consumes its wrapped, sign-extended accumulator output. Every R-th sample it takes the comb difference against the previous decimated sample, rounds and rescales the result back to the original sample width, and delivers it through a 2-entry valid/ready output buffer.

## Interface
Parameters:
- DW, 23, width of the accumulator input; equals the integrator output width.
- IDW, 16, original signed sample width; also the output width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock; one input sample per cycle.
- reset  in  1  synchronous, active-high.
- os_sel  in  3  oversampling select, same encoding as the integrator.
- data_in  in  DW  integrator accumulator value.
- out_data  out  IDW  signed decimated sample; FIFO head.
- out_valid  out  1  out_data holds a valid sample.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready.
- ovf  out  1  one-cycle pulse: a decimated sample was dropped because the FIFO was full.

## Operation
- Rate and width from os_sel:
  - os_sel 1..6: R = 2^os_sel, k = os_sel, W = IDW+k.
  - os_sel 0 or 7: R = 1, k = 0, W = DW.
- Decimation counter cnt runs 0..R-1. A tick occurs when cnt == R-1; cnt then wraps to 0. When R = 1, every cycle is a tick.
- State machine:
  - PRIME: on a tick, s_prev <= data_in[W-1:0]; no output; go to RUN.
  - RUN: on a tick, diff = (data_in[W-1:0] - s_prev) mod 2^W, read as W-bit signed; s_prev <= data_in[W-1:0].
- Scaling: k > 0 gives y = (diff + 2^(k-1)) >>> k; k = 0 gives y = diff. y is computed in W+1 bits and saturated to the signed IDW range.
- os_sel change: os_sel_q is the registered copy of os_sel. If os_sel != os_sel_q at an edge:
  - cnt <= 0, state <= PRIME, the in-flight comb result is discarded, os_sel_q <= os_sel.
  - FIFO contents are kept.
  - A tick coinciding with the change is discarded.
- FIFO (2 entries):
  - Push occurs when the scaled result is valid.
  - Pop occurs when out_valid && out_ready.
  - Pop is evaluated before push, so push while full with a simultaneous pop is accepted.
  - Push while full without a pop: the new sample is dropped and ovf = 1 for one cycle.

## Timing
- Reset values: out_data = 0, out_valid = 0, ovf = 0, cnt = 0, state = PRIME, s_prev = 0, FIFO empty, os_sel_q <= os_sel (no spurious change after reset).
- Latency, with the tick at edge t:
  - diff is registered at edge t.
  - Round/saturate result is pushed at edge t+1.
  - out_valid = 1 after edge t+1 if the FIFO was empty.
- Throughput: at most one push per R cycles. Sustains one pop per cycle.
- ovf is asserted in the cycle after the dropped push edge.
- Reset asserted mid-operation restores all reset values at the next edge. Buffered samples are lost.

## Structure
- Package cic_pkg:
  - state enum {PRIME, RUN}.
  - function os_params(os_sel) returning R-1, k and W.
  - os_sel encoding constants shared with the integrator.
- Sub-module cic_out_fifo: 2-entry valid/ready buffer with pop-before-push and a full/drop indication.
- Top level: counter, FSM, comb/round/saturate pipeline.

## Test plan
- Reset: hold reset 3 cycles with out_ready = 1 → out_data = 0, out_valid = 0, ovf = 0, with no output for the first R cycles after release.
- R = 4 steady state: os_sel = 2, data_in = 1000·n (constant input 1000) → the first tick only primes. Afterwards out_data = 1000 every 4 cycles, valid 2 cycles after each tick.
- Wrap: os_sel = 1 (W = 17), s_prev = 17'h0FFF0, next tick data_in[16:0] = 17'h1FFF0 → diff = -65536, out_data = -32768.
- Round/saturate:
  - os_sel = 1, diff = 3 → 2.
  - os_sel = 1, diff = 65534 → 32767.
  - os_sel = 0, data_in step +40000 → 32767.
- Backpressure: os_sel = 1, out_ready = 0, three ticks → FIFO holds samples 1 and 2. The third is dropped and ovf pulses once. Raising out_ready then delivers samples 1 and 2 in order.
- os_sel change: switch 2 → 1 when cnt = 2 → the FIFO keeps its contents, the next tick primes, and output resumes at the following tick with R = 2 scaling.

Source files
------------

// File: rtl/cic_comb_decimator_pkg.sv
// cic_pkg: shared definitions for the CIC decimator comb stage.
//   state_t      : comb FSM states (PRIME waits for the first decimated
//                  sample, RUN produces a comb difference on every tick).
//   OS_* consts  : oversampling-select encoding shared with the integrator.
//   os_params()  : maps os_sel to decimation ratio minus one, shift k and
//                  working width W.
package cic_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Both ends of the 3-bit code mean "no decimation, full accumulator width".
    localparam logic [2:0] OS_BYPASS     = 3'd0;
    localparam logic [2:0] OS_BYPASS_ALT = 3'd7;

    typedef struct packed {
        logic [5:0] r_m1;  // decimation ratio R minus one (0..63)
        logic [2:0] k;     // log2(R), also the output rescale shift
        logic [5:0] w;     // working width of the comb difference
    } os_params_t;

    function automatic os_params_t os_params(input logic [2:0] os_sel,
                                             input int         dw,
                                             input int         idw);
        os_params_t p;
        if (os_sel == OS_BYPASS || os_sel == OS_BYPASS_ALT) begin
            p.r_m1 = 6'd0;
            p.k    = 3'd0;
            p.w    = 6'(dw);
        end else begin
            p.r_m1 = 6'((1 << os_sel) - 1);
            p.k    = os_sel;
            p.w    = 6'(idw + int'(os_sel));
        end
        return p;
    endfunction

endpackage

// File: rtl/cic_comb_decimator_fifo.sv
// cic_out_fifo: 2-entry valid/ready output buffer.
//   clk, reset  : clock, synchronous active-high reset (empties the buffer).
//   push        : a new sample is offered this cycle.
//   push_data   : sample offered with push.
//   pop_ready   : consumer accepts the head when head_valid is also high.
//   head_data   : oldest buffered sample.
//   head_valid  : head_data holds a valid sample.
//   ovf         : one-cycle pulse after a push was dropped because the
//                 buffer was full and nothing was popped on that edge.
module cic_out_fifo #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic signed [W-1:0] push_data,
    input  logic                pop_ready,
    output logic signed [W-1:0] head_data,
    output logic                head_valid,
    output logic                ovf
);

    logic signed [W-1:0] mem [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;
    logic                pop;
    logic                accept;

    assign head_valid = (count != 2'd0);
    assign head_data  = mem[rd_ptr];
    assign pop        = head_valid && pop_ready;
    // A pop frees the slot on the same edge, so a full buffer still takes
    // the push when the consumer drains it simultaneously.
    assign accept     = push && ((count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            ovf    <= 1'b0;
        end else begin
            ovf <= push && !accept;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            count <= count + 2'(accept) - 2'(pop);
        end
    end

endmodule

// File: rtl/cic_comb_decimator.sv
// cic_comb_decimator: decimation + comb stage of a single-stage CIC
// decimator. Every R-th accumulator sample is differenced against the
// previous decimated sample, rounded, rescaled to IDW bits, saturated and
// queued in a 2-entry output buffer.
//   clk       : rising-edge clock, one input sample per cycle.
//   reset     : synchronous, active-high.
//   os_sel    : oversampling select (R = 2^os_sel for 1..6, R = 1 for 0/7).
//   data_in   : integrator accumulator value (wrapping).
//   out_data  : decimated signed sample at the buffer head.
//   out_valid : out_data is valid.
//   out_ready : consumer accepts the head when out_valid is also high.
//   ovf       : one-cycle pulse when a decimated sample was dropped.
module cic_comb_decimator
    import cic_pkg::*;
#(
    parameter int DW  = 23,
    parameter int IDW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            os_sel,
    input  logic [DW-1:0]         data_in,
    output logic signed [IDW-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf
);

    localparam logic signed [DW:0] SAT_MAX = (DW+1)'((2 ** (IDW-1)) - 1);
    localparam logic signed [DW:0] SAT_MIN = (DW+1)'(-(2 ** (IDW-1)));

    // Round half up, then arithmetic shift by k; one guard bit above DW
    // keeps the rounding add from overflowing.
    function automatic logic signed [DW:0] round_shift(input logic signed [DW-1:0] d,
                                                       input logic [2:0]           k);
        logic signed [DW:0] x;
        logic signed [DW:0] half;
        logic signed [DW:0] res;
        x    = {d[DW-1], d};
        half = '0;
        if (k == 3'd0) begin
            res = x;
        end else begin
            half[k - 3'd1] = 1'b1;
            res = (x + half) >>> k;
        end
        return res;
    endfunction

    function automatic logic signed [IDW-1:0] saturate(input logic signed [DW:0] v);
        logic signed [IDW-1:0] res;
        if (v > SAT_MAX) begin
            res = {1'b0, {(IDW-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            res = {1'b1, {(IDW-1){1'b0}}};
        end else begin
            res = v[IDW-1:0];
        end
        return res;
    endfunction

    logic [2:0]            os_sel_q;
    os_params_t            prm;
    logic                  chg;
    logic [5:0]            cnt;
    logic                  tick;
    state_t                state;
    state_t                state_nxt;
    logic                  comb_fire;
    logic [DW-1:0]         w_mask;
    logic [DW-1:0]         sample_p0;
    logic [DW-1:0]         s_prev;
    logic [DW-1:0]         diff_raw_p0;
    logic signed [DW-1:0]  diff_shl_p0;
    logic signed [DW-1:0]  diff_sx_p0;
    int                    sh;
    logic signed [DW-1:0]  diff_p1;
    logic                  vld_p1;
    logic signed [IDW-1:0] y_p2;
    logic                  vld_p2;

    // Rate parameters follow the registered select so a change takes effect
    // only after the edge that restarts the decimator.
    assign prm  = os_params(os_sel_q, DW, IDW);
    assign chg  = (os_sel != os_sel_q);
    assign tick = (cnt == prm.r_m1);

    // ---- stage p0: modulo-2^W comb difference, sign-extended from bit W-1
    assign sh          = DW - int'(prm.w);
    assign w_mask      = {DW{1'b1}} >> sh;
    assign sample_p0   = data_in & w_mask;
    assign diff_raw_p0 = sample_p0 - s_prev;
    assign diff_shl_p0 = diff_raw_p0 << sh;
    assign diff_sx_p0  = diff_shl_p0 >>> sh;

    always_comb begin
        state_nxt = state;
        comb_fire = 1'b0;
        if (chg) begin
            state_nxt = PRIME;
        end else if (tick) begin
            case (state)
                PRIME:   state_nxt = RUN;
                RUN:     comb_fire = 1'b1;
                default: state_nxt = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            os_sel_q <= os_sel;
            cnt      <= 6'd0;
            state    <= PRIME;
            s_prev   <= '0;
            vld_p1   <= 1'b0;
        end else begin
            os_sel_q <= os_sel;
            state    <= state_nxt;
            if (chg) begin
                cnt    <= 6'd0;
                vld_p1 <= 1'b0;
            end else begin
                cnt    <= tick ? 6'd0 : cnt + 6'd1;
                vld_p1 <= comb_fire;
                if (tick) begin
                    s_prev <= sample_p0;
                end
            end
        end
    end

    // ---- stage p1: registered comb difference
    always_ff @(posedge clk) begin
        if (comb_fire && !chg) begin
            diff_p1 <= diff_sx_p0;
        end
    end

    // ---- stage p2: round, rescale, saturate; pushed into the buffer
    // A select change on this edge discards the result still in flight.
    assign y_p2   = saturate(round_shift(diff_p1, prm.k));
    assign vld_p2 = vld_p1 && !chg;

    cic_out_fifo #(
        .W (IDW)
    ) u_out_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (vld_p2),
        .push_data  (y_p2),
        .pop_ready  (out_ready),
        .head_data  (out_data),
        .head_valid (out_valid),
        .ovf        (ovf)
    );

endmodule
